// File: rtl/hq_metric_select.sv
// hq_metric_select: matched-filter energy metric per Hq candidate and arg-max over 16 candidates
module hq_metric_select #(
    parameter int N         = 16,
    parameter int SHIFT     = 15,
    parameter int ACC_WIDTH = 2*N+3,
    parameter int MET_WIDTH = 2*N+2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 y_in_valid,
    input  logic signed [N-1:0]  y_in_r,
    input  logic signed [N-1:0]  y_in_i,
    input  logic                 hq_in_valid,
    input  logic signed [N-1:0]  hq_in_r,
    input  logic signed [N-1:0]  hq_in_i,
    output logic                 busy,
    output logic                 metric_valid,
    output logic [3:0]           metric_q,
    output logic [MET_WIDTH-1:0] metric_out,
    output logic                 sel_done,
    output logic [3:0]           best_q,
    output logic [MET_WIDTH-1:0] best_metric
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_Y, S_RUN, S_FINISH} state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(2**(N-1)-1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

    state_t state, state_nx;

    logic signed [N-1:0]         y_r [4];
    logic signed [N-1:0]         y_i [4];
    logic [1:0]                  y_cnt;
    logic [3:0]                  beat, mat;
    logic signed [ACC_WIDTH-1:0] acc_r [4];
    logic signed [ACC_WIDTH-1:0] acc_i [4];
    logic signed [ACC_WIDTH-1:0] sh_r [4];
    logic signed [ACC_WIDTH-1:0] sh_i [4];

    // metric engine: ph 1..4 accumulate k = ph-1, ph 5 publishes the result
    logic [2:0]                  ph;
    logic [3:0]                  eng_q;
    logic [MET_WIDTH-1:0]        eng_m;

    logic go, y_fire, hq_fire, last_beat;
    logic [1:0] row, col, ek;
    logic signed [2*N-1:0] p_rr, p_ii, p_ri, p_ir, sq_r, sq_i;
    logic signed [ACC_WIDTH-1:0] sum_r, sum_i;
    logic signed [N-1:0] pt_r, pt_i;
    logic [MET_WIDTH-1:0] term;

    // scale a projection down and clamp it into the N-bit signed range
    function automatic logic signed [N-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] s;
        s = v >>> SHIFT;
        return (s > SAT_HI) ? SAT_HI[N-1:0] : (s < SAT_LO) ? SAT_LO[N-1:0] : s[N-1:0];
    endfunction

    assign go        = (state == S_IDLE) && start;
    assign y_fire    = (state == S_LOAD_Y) && y_in_valid;
    assign hq_fire   = (state == S_RUN) && hq_in_valid;
    assign last_beat = hq_fire && (beat == 4'd15);
    assign row       = beat[3:2];
    assign col       = beat[1:0];

    // conj(H)*y contribution of the current element, in full precision
    assign p_rr  = (2*N)'(hq_in_r) * (2*N)'(y_r[row]);
    assign p_ii  = (2*N)'(hq_in_i) * (2*N)'(y_i[row]);
    assign p_ri  = (2*N)'(hq_in_r) * (2*N)'(y_i[row]);
    assign p_ir  = (2*N)'(hq_in_i) * (2*N)'(y_r[row]);
    assign sum_r = acc_r[col] + ACC_WIDTH'(p_rr) + ACC_WIDTH'(p_ii);
    assign sum_i = acc_i[col] + ACC_WIDTH'(p_ri) - ACC_WIDTH'(p_ir);

    assign ek    = ph[1:0] - 2'd1;
    assign pt_r  = sat(sh_r[ek]);
    assign pt_i  = sat(sh_i[ek]);
    assign sq_r  = (2*N)'(pt_r) * (2*N)'(pt_r);
    assign sq_i  = (2*N)'(pt_i) * (2*N)'(pt_i);
    assign term  = MET_WIDTH'($unsigned(sq_r)) + MET_WIDTH'($unsigned(sq_i));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_LOAD_Y;
            S_LOAD_Y: if (y_in_valid && y_cnt == 2'd3) state_nx = S_RUN;
            S_RUN:    if (last_beat && mat == 4'd15) state_nx = S_FINISH;
            S_FINISH: if (sel_done) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // state-derived outputs
    always_comb begin
        busy = (state != S_IDLE);
    end

    // y capture, beat/matrix counting, projection accumulation and shadow copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_cnt <= '0;
            beat  <= '0;
            mat   <= '0;
            for (int j = 0; j < 4; j++) begin
                y_r[j]   <= '0;
                y_i[j]   <= '0;
                acc_r[j] <= '0;
                acc_i[j] <= '0;
                sh_r[j]  <= '0;
                sh_i[j]  <= '0;
            end
        end else if (go) begin
            y_cnt <= '0;
            beat  <= '0;
            mat   <= '0;
            for (int j = 0; j < 4; j++) begin
                acc_r[j] <= '0;
                acc_i[j] <= '0;
            end
        end else begin
            if (y_fire) begin
                y_r[y_cnt] <= y_in_r;
                y_i[y_cnt] <= y_in_i;
                y_cnt      <= y_cnt + 2'd1;
            end
            if (hq_fire) begin
                beat <= beat + 4'd1;
                if (beat == 4'd15) begin
                    mat <= mat + 4'd1;
                    for (int j = 0; j < 4; j++) begin
                        sh_r[j]  <= (2'(j) == col) ? sum_r : acc_r[j];
                        sh_i[j]  <= (2'(j) == col) ? sum_i : acc_i[j];
                        acc_r[j] <= '0;
                        acc_i[j] <= '0;
                    end
                end else begin
                    acc_r[col] <= sum_r;
                    acc_i[col] <= sum_i;
                end
            end
        end
    end

    // metric engine, metric reporting and running maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph           <= '0;
            eng_q        <= '0;
            eng_m        <= '0;
            metric_valid <= 1'b0;
            metric_q     <= '0;
            metric_out   <= '0;
            sel_done     <= 1'b0;
            best_q       <= '0;
            best_metric  <= '0;
        end else begin
            metric_valid <= 1'b0;
            sel_done     <= 1'b0;
            if (go) begin
                ph          <= '0;
                best_q      <= '0;
                best_metric <= '0;
            end else if (last_beat) begin
                ph    <= 3'd1;
                eng_m <= '0;
                eng_q <= mat;
            end else if (ph != 3'd0 && ph != 3'd5) begin
                eng_m <= eng_m + term;
                ph    <= ph + 3'd1;
            end else if (ph == 3'd5) begin
                ph           <= '0;
                metric_valid <= 1'b1;
                metric_q     <= eng_q;
                metric_out   <= eng_m;
                sel_done     <= (eng_q == 4'd15);
                if (eng_m > best_metric || eng_q == 4'd0) begin
                    best_q      <= eng_q;
                    best_metric <= eng_m;
                end
            end
        end
    end

endmodule

// File: doc/hq_metric_select.md
# hq_metric_select

Downstream stage of the Hq generator. Holds a 4-element complex receive vector y and consumes the stream of 16 candidate 4x4 complex Hq matrices, one per q index. For each matrix it forms the matched-filter projections P_k = Σ_i conj(Hq[i][k])·y[i] and the energy metric m_q = Σ_k |P_k|². It reports each metric and, after the 16th matrix, the index and value of the maximum.

## Interface
- N, 16, sample width (signed real/imag)
- SHIFT, 15, arithmetic right shift applied to P_k before squaring
- ACC_WIDTH, 2N+3, projection accumulator width (signed)
- MET_WIDTH, 2N+2, metric width (unsigned)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run; honoured only in S_IDLE
- y_in_valid  in  1  y beat strobe
- y_in_r, y_in_i  in  N  signed y[i]; 4 beats, i = 0..3
- hq_in_valid  in  1  Hq beat strobe; no backpressure
- hq_in_r, hq_in_i  in  N  signed Hq element, row-major, k fastest
- busy  out  1  high outside S_IDLE
- metric_valid  out  1  one-cycle pulse per matrix
- metric_q  out  4  matrix index of metric_out
- metric_out  out  MET_WIDTH  m_q
- sel_done  out  1  one-cycle pulse after the 16th metric
- best_q  out  4  index of maximum metric
- best_metric  out  MET_WIDTH  maximum metric

## Operation
- FSM states: S_IDLE, S_LOAD_Y, S_RUN, S_FINISH.
- S_IDLE → S_LOAD_Y on start. Clears the y counter, beat counter (0..15), matrix counter (0..15), the accumulators, best_q and best_metric.
- S_LOAD_Y: each y_in_valid beat writes y[cnt]. After the 4th beat, the FSM goes to S_RUN. hq beats are ignored in this state.
- S_RUN: each hq_in_valid beat with element (i,k), where i = beat[3:2] and k = beat[1:0], accumulates:
  - re += Hr·yr + Hi·yi
  - im += Hr·yi − Hi·yr
  - both into P_k, full precision.
- On the 16th beat of a matrix:
  - Final P_0..3 are copied to shadow registers.
  - The accumulators clear so the next beat starts a new matrix.
  - The metric engine launches with the matrix counter value as its q.
- Metric engine runs 4 cycles, one k per cycle:
  - Pt = saturate_N(P_k >>> SHIFT), applied to re and im separately.
  - m += Pt_r² + Pt_i², unsigned.
  - It then registers the result (see Timing).
- Max tracking: best_q/best_metric update when m_q > best_metric, or when q = 0. This is a strict compare, so the lowest q wins on ties.
- After the 16th matrix's 16th beat, the FSM enters S_FINISH. It returns to S_IDLE in the cycle sel_done pulses.
- y, start and hq strobes outside their states are ignored. start while busy is ignored.
- best_q/best_metric hold until the next start.

## Timing
- Reset values: all outputs 0, including busy, metric_valid, sel_done, best_q, best_metric, metric_q and metric_out. State S_IDLE.
- Reset is asynchronous: asserting rst_n mid-run aborts immediately. No metric_valid or sel_done is produced for the partial run.
- busy rises the cycle after start is sampled.
- The 4th y beat is accepted at edge E. hq beats are accepted from edge E+1.
- Let edge T accept a matrix's 16th beat. Then metric_valid, metric_q, metric_out, and any best update are all registered at edge T+5.
- sel_done is registered at the same edge as the 16th metric_valid, with best_q/best_metric already final. busy falls one edge later.
- Matrices may arrive back-to-back with no gaps (256 consecutive beats). The engine occupancy of 5 cycles is less than 16, so no beat is lost. Arbitrary gaps between beats are also legal.
- Saturation bounds are +32767 and −32768. The largest Pt² is 2^30, and the metric fits in MET_WIDTH with no wrap.

## Test plan
- **Single peak.** Input: y[i] = (16384,0); all Hq zero except q=5, which is all (16384,0).
  - m_5 = 4·32767² = 4294705156, since P = 2^30 saturates to 32767.
  - Every other metric = 0.
  - best_q = 5, best_metric = 4294705156.
- **Negative path.** Input: y[i] = (16384,0); q=9 all (0,16384); q=5 as above.
  - P_im = −2^30 → −32768, with no saturation.
  - m_9 = 4294967296.
  - best_q = 9.
- **Tie.** Input: all 16 matrices identical and nonzero.
  - best_q = 0.
  - 16 metric_valid pulses with metric_q = 0..15.
- **Back-to-back.** Input: 256 consecutive hq beats.
  - Each metric_valid arrives exactly 5 cycles after its matrix's 16th beat.
  - sel_done arrives with the 16th metric_valid.
  - busy falls one cycle later.
- **Reset mid-run.** Input: rst_n low after 8 matrices.
  - All outputs read 0 immediately; state S_IDLE.
  - Subsequent hq beats are ignored until start plus 4 y beats.
- **Start while busy.** Input: start pulsed during S_RUN.
  - No effect; the run completes with the correct best_q.
